// File: rtl/fetch_aligner.sv
// fetch_aligner: realigns word-wide instruction memory reads into whole instructions for decode.
// Define C_EXT_EN to accept 16-bit compressed instructions (3-halfword buffer); otherwise every word is one instruction.
module fetch_aligner (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        IF_valid,
   input  logic        IF_ready,
   output logic [31:0] IF_Instr_32,
   output logic [15:0] IF_Instr_16,
   output logic        IF_is_c,
   output logic [31:0] IF_pc
);

`ifdef C_EXT_EN
   localparam bit C_EN  = 1'b1;
   localparam int DEPTH = 3;
`else
   localparam bit C_EN  = 1'b0;
   localparam int DEPTH = 2;
`endif
   localparam int FW = 16 * DEPTH;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [FW-1:0] fifo, fifo_nxt, fifo_shift, app_data, keep_mask;
   logic [1:0]    cnt, cnt_nxt, cnt_shift, used, added;
   logic [31:0]   pc, fetch_addr, app_word;
   logic          skip_lo, lo_is_c, complete, fire, accept;
   logic          unused_pc_bit;

   assign unused_pc_bit = redirect_pc[0];

   // Slot 0 is the oldest halfword; a 32-bit instruction needs two buffered halfwords.
   assign lo_is_c   = C_EN && (cnt != 2'd0) && (fifo[1:0] != 2'b11);
   assign complete  = lo_is_c || (cnt >= 2'd2);
   assign fire      = complete && !redirect && IF_ready;
   assign accept    = (state == WAIT) && mem_rvalid && !redirect;
   assign used      = !fire ? 2'd0 : (lo_is_c ? 2'd1 : 2'd2);
   assign added     = !accept ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
   assign cnt_shift = cnt - used;
   assign cnt_nxt   = cnt_shift + added;

   // Consume from the bottom first, then append the response above what is left.
   always_comb begin
      app_word   = skip_lo ? {16'h0000, mem_rdata[31:16]} : mem_rdata;
      fifo_shift = fifo >> {used, 4'b0000};
      app_data   = FW'(app_word) << {cnt_shift, 4'b0000};
      keep_mask  = ~({FW{1'b1}} << {cnt_shift, 4'b0000});
      fifo_nxt   = accept ? ((fifo_shift & keep_mask) | app_data) : fifo_shift;
   end

   always_ff @(posedge clk) begin
      fifo <= fifo_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A redirect from IDLE requests the new target on the very next cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (redirect || (cnt_shift <= 2'd1)) state_nxt = WAIT;
         end
         WAIT: begin
            if (redirect)        state_nxt = mem_rvalid ? IDLE : DROP;
            else if (mem_rvalid) state_nxt = IDLE;
         end
         DROP: begin
            if (mem_rvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_req     = (state == WAIT);
      mem_addr    = fetch_addr;
      IF_valid    = complete && !redirect;
      IF_is_c     = IF_valid && lo_is_c;
      IF_Instr_16 = IF_valid ? fifo[15:0] : 16'h0000;
      IF_Instr_32 = !IF_valid ? 32'h0000_0000 :
                    (lo_is_c ? {16'h0000, fifo[15:0]} : fifo[31:0]);
      IF_pc       = pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= 2'd0;
         pc         <= 32'h0000_0000;
         fetch_addr <= 32'h0000_0000;
         skip_lo    <= 1'b0;
      end else if (redirect) begin
         cnt        <= 2'd0;
         pc         <= C_EN ? {redirect_pc[31:1], 1'b0} : {redirect_pc[31:2], 2'b00};
         fetch_addr <= {redirect_pc[31:2], 2'b00};
         skip_lo    <= C_EN && redirect_pc[1];
      end else begin
         cnt <= cnt_nxt;
         if (fire) pc <= pc + (lo_is_c ? 32'd2 : 32'd4);
         if (accept) begin
            fetch_addr <= fetch_addr + 32'd4;
            skip_lo    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: vector table, directed stall/reset sequences and a randomized run against an instruction-stream model.
module tb_fetch_aligner;

`ifdef C_EXT_EN
   localparam bit C_EN = 1'b1;
`else
   localparam bit C_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        IF_valid;
   logic        IF_ready = 1'b0;
   logic [31:0] IF_Instr_32;
   logic [15:0] IF_Instr_16;
   logic        IF_is_c;
   logic [31:0] IF_pc;

   int checks = 0;
   int errors = 0;

   fetch_aligner dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .IF_valid    (IF_valid),
      .IF_ready    (IF_ready),
      .IF_Instr_32 (IF_Instr_32),
      .IF_Instr_16 (IF_Instr_16),
      .IF_is_c     (IF_is_c),
      .IF_pc       (IF_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   typedef struct {
      bit          rst;
      bit          redir;
      logic [31:0] rpc;
      bit          rv;
      logic [31:0] rdata;
      bit          rdy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_i32;
      bit          e_c;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input bit rst, input bit redir, input logic [31:0] rpc,
                    input bit rv, input logic [31:0] rdata, input bit rdy,
                    input bit e_req, input logic [31:0] e_addr, input bit e_valid,
                    input logic [31:0] e_pc, input logic [31:0] e_i32, input bit e_c);
      vec_t t;
      t.rst = rst; t.redir = redir; t.rpc = rpc; t.rv = rv; t.rdata = rdata; t.rdy = rdy;
      t.e_req = e_req; t.e_addr = e_addr; t.e_valid = e_valid;
      t.e_pc = e_pc; t.e_i32 = e_i32; t.e_c = e_c;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      redirect = 1'b0; redirect_pc = 32'h0; mem_rvalid = 1'b0; mem_rdata = 32'h0; IF_ready = 1'b0;
   endtask

   // Reset spans one full edge; returns #1 after the edge where rst_n was released.
   task automatic reset_release();
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive_idle();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Reference memory and instruction stream, independent of buffering details.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] x;
      x = {a[31:2], 2'b00} * 32'h9E37_79B1;
      x = x ^ (x >> 15);
      x = x * 32'h85EB_CA6B;
      return x ^ (x >> 13);
   endfunction

   function automatic logic [15:0] mem_hw(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word(a);
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic logic [31:0] ref_instr(input logic [31:0] pc);
      logic [15:0] h0;
      if (!C_EN) return mem_word(pc);
      h0 = mem_hw(pc);
      if (h0[1:0] != 2'b11) return {16'h0000, h0};
      return {mem_hw(pc + 32'd2), h0};
   endfunction

   initial begin
      logic [31:0] exp_pc, req_a, tgt, ri, stable_i;
      bit          pend, resp, redir;
      int          dly, n_fire, bad_align;

      // ---- vector table ----
      // two c.nop (or one 32-bit word without compressed support)
      v(1,0,0,            0,0,1,            0,0,         0,0,0,0);
      v(0,0,0,            1,32'h0001_0001,1, 1,0,         0,0,0,0);
      v(0,0,0,            0,0,1,            0,4,         1,0, C_EN ? 32'h1 : 32'h0001_0001, C_EN);
      v(0,0,0,            0,0,1,            1,4,         C_EN, C_EN ? 32'h2 : 32'h4, C_EN ? 32'h1 : 32'h0, C_EN);
      v(0,0,0,            0,0,1,            1,4,         0,4,0,0);
`ifdef C_EXT_EN
      // c.nop then a 32-bit instruction straddling two words
      v(1,0,0,            0,0,1,            0,0,         0,0,0,0);
      v(0,0,0,            1,32'h0013_0001,1, 1,0,         0,0,0,0);
      v(0,0,0,            0,0,1,            0,4,         1,0,32'h1,1);
      v(0,0,0,            0,0,1,            1,4,         0,2,0,0);
      v(0,0,0,            1,32'h0001_0000,1, 1,4,         0,2,0,0);
      v(0,0,0,            0,0,1,            0,8,         1,2,32'h13,0);
      v(0,0,0,            0,0,1,            1,8,         1,6,32'h1,1);
`endif
      // redirect to 0x102 from IDLE
      v(1,1,32'h102,      0,0,1,            0,0,         0,0,0,0);
      v(0,0,0,            1,32'h0005_BEEF,1, 1,32'h100,   0, C_EN ? 32'h102 : 32'h100, 0,0);
      v(0,0,0,            0,0,1,            0,32'h104,   1, C_EN ? 32'h102 : 32'h100,
        C_EN ? 32'h5 : 32'h0005_BEEF, C_EN);
      v(0,0,0,            0,0,1,            1,32'h104,   0,32'h104,0,0);
      // redirect in WAIT, stale all-ones response three cycles later
      v(1,0,0,            0,0,1,            0,0,         0,0,0,0);
      v(0,1,32'h40,       0,0,1,            1,0,         0,0,0,0);
      v(0,0,0,            0,0,1,            0,32'h40,    0,32'h40,0,0);
      v(0,0,0,            0,0,1,            0,32'h40,    0,32'h40,0,0);
      v(0,0,0,            1,32'hFFFF_FFFF,1, 0,32'h40,    0,32'h40,0,0);
      v(0,0,0,            0,0,0,            0,32'h40,    0,32'h40,0,0);
      v(0,0,0,            1,32'h0001_0001,0, 1,32'h40,    0,32'h40,0,0);
      v(0,0,0,            0,0,0,            0,32'h44,    1,32'h40, C_EN ? 32'h1 : 32'h0001_0001, C_EN);
      // redirect coinciding with the response
      v(1,0,0,            0,0,1,            0,0,         0,0,0,0);
      v(0,1,32'h80,       1,32'h0001_0001,1, 1,0,         0,0,0,0);
      v(0,0,0,            0,0,1,            0,32'h80,    0,32'h80,0,0);
      v(0,0,0,            0,0,1,            1,32'h80,    0,32'h80,0,0);
      // PC and fetch address wrap at the top of memory
      v(1,1,32'hFFFF_FFFC,0,0,1,            0,0,         0,0,0,0);
      v(0,0,0,            1,32'h0001_0001,1, 1,32'hFFFF_FFFC, 0,32'hFFFF_FFFC,0,0);
      v(0,0,0,            0,0,1,            0,0,         1,32'hFFFF_FFFC, C_EN ? 32'h1 : 32'h0001_0001, C_EN);
      v(0,0,0,            0,0,1,            1,0,         C_EN, C_EN ? 32'hFFFF_FFFE : 32'h0, C_EN ? 32'h1 : 32'h0, C_EN);

      foreach (vecs[i]) begin
         if (vecs[i].rst) reset_release();
         else begin
            @(posedge clk); #1;
         end
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         mem_rvalid  = vecs[i].rv;
         mem_rdata   = vecs[i].rdata;
         IF_ready    = vecs[i].rdy;
         @(negedge clk);
         chkb($sformatf("row%0d_mem_req", i), mem_req, vecs[i].e_req);
         chk ($sformatf("row%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
         chkb($sformatf("row%0d_if_valid", i), IF_valid, vecs[i].e_valid);
         chk ($sformatf("row%0d_if_pc", i), IF_pc, vecs[i].e_pc);
         if (vecs[i].e_valid) begin
            chk ($sformatf("row%0d_instr32", i), IF_Instr_32, vecs[i].e_i32);
            chk ($sformatf("row%0d_instr16", i), {16'h0, IF_Instr_16}, {16'h0, vecs[i].e_i32[15:0]});
            chkb($sformatf("row%0d_is_c", i), IF_is_c, vecs[i].e_c);
         end
      end

      // ---- downstream stall with a full 32-bit instruction buffered ----
      reset_release();
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; IF_ready = 1'b0;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      stable_i = IF_Instr_32;
      chk("stall_first_instr", IF_Instr_32, 32'hDEAD_BEEF);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chkb($sformatf("stall%0d_no_req", k), mem_req, 1'b0);
         chkb($sformatf("stall%0d_valid", k), IF_valid, 1'b1);
         chk ($sformatf("stall%0d_instr", k), IF_Instr_32, stable_i);
      end
      chk("stall_pc", IF_pc, 32'h0);

      // ---- reset while a request is outstanding ----
      reset_release();
      @(posedge clk); #1;
      @(negedge clk);
      chkb("rstwait_req_before", mem_req, 1'b1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      chkb("rstwait_mem_req", mem_req, 1'b0);
      chk ("rstwait_mem_addr", mem_addr, 32'h0);
      chkb("rstwait_valid", IF_valid, 1'b0);
      chk ("rstwait_pc", IF_pc, 32'h0);
      chk ("rstwait_instr32", IF_Instr_32, 32'h0);
      chkb("rstwait_is_c", IF_is_c, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chkb("rstwait_stale_valid", IF_valid, 1'b0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      chkb("rstwait_restart_req", mem_req, 1'b1);
      chk ("rstwait_restart_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'h0001_0001;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      chkb("rstwait_after_valid", IF_valid, 1'b1);
      chk ("rstwait_after_pc", IF_pc, 32'h0);
      chk ("rstwait_after_instr", IF_Instr_32, C_EN ? 32'h1 : 32'h0001_0001);

      // ---- randomized run against the instruction-stream model ----
      reset_release();
      exp_pc = 32'h0; pend = 1'b0; dly = 0; req_a = 32'h0;
      n_fire = 0; bad_align = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         resp = 1'b0;
         mem_rvalid = 1'b0; mem_rdata = 32'h0;
         if (pend) begin
            if (dly == 0) begin
               mem_rvalid = 1'b1; mem_rdata = mem_word(req_a); pend = 1'b0; resp = 1'b1;
            end else dly--;
         end
         if (!pend && !resp && mem_req) begin
            pend = 1'b1; req_a = mem_addr; dly = int'($urandom_range(2, 0));
         end
         if (mem_req && (mem_addr[1:0] != 2'b00)) bad_align++;
         redir = ($urandom_range(24, 0) == 0);
         tgt = $urandom;
         redirect = redir;
         redirect_pc = tgt;
         IF_ready = ($urandom_range(3, 0) != 0);
         @(negedge clk);
         if (redir) begin
            chkb("rand_valid_during_redirect", IF_valid, 1'b0);
            exp_pc = C_EN ? {tgt[31:1], 1'b0} : {tgt[31:2], 2'b00};
         end else if (IF_valid && IF_ready) begin
            ri = ref_instr(exp_pc);
            chk ("rand_pc", IF_pc, exp_pc);
            chk ("rand_instr32", IF_Instr_32, ri);
            chkb("rand_is_c", IF_is_c, C_EN && (ri[1:0] != 2'b11));
            exp_pc = exp_pc + ((C_EN && (ri[1:0] != 2'b11)) ? 32'd2 : 32'd4);
            n_fire++;
         end
      end
      chk("rand_misaligned_requests", 32'(bad_align), 32'h0);
      chkb("rand_progress", n_fire > 200, 1'b1);

      drive_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 redirect  input  1  flush-and-restart request (branch/jump/trap).
REQ-004 redirect_pc  input  32  new fetch PC; bit0 ignored (halfword-aligned).
REQ-005 mem_req  output  1  instruction-memory read request, held until response.
REQ-006 mem_addr  output  32  word address; bits[1:0] always 00.
REQ-007 mem_rvalid  input  1  read data valid; one response per request, in any cycle after mem_req.
REQ-008 mem_rdata  input  32  fetched word, little-endian halfwords.
REQ-009 IF_valid  output  1  complete instruction available.
REQ-010 IF_ready  input  1  downstream accepts the instruction this cycle.
REQ-011 IF_Instr_32  output  32  uncompressed instruction; upper 16 bits zero when compressed.
REQ-012 IF_Instr_16  output  16  low halfword of the current instruction, wired to the decompression stage.
REQ-013 IF_is_c  output  1  current instruction is 16-bit (low halfword bits[1:0] != 11).
REQ-014 IF_pc  output  32  PC of the current instruction.

Function
REQ-015 The buffer SHALL be a 3-halfword FIFO (48 bits) plus a 2-bit count (0..3); slot 0 is the oldest halfword.
REQ-016 An instruction SHALL be complete when count>=1 and slot0[1:0]!=11, or when count>=2; IF_valid = complete, combinational from registers.
REQ-017 On IF_valid&IF_ready the FIFO SHALL shift by 1 (compressed) or 2 (32-bit), and IF_pc SHALL advance by 2 or 4.
REQ-018 FSM states: IDLE, WAIT, DROP.
REQ-019 IDLE->WAIT SHALL occur when (count after the same-cycle consume) <=1 and no redirect; mem_req=1 in WAIT.
REQ-020 WAIT->IDLE on mem_rvalid; both halfwords SHALL be appended (or only the upper halfword when the skip_lo flag is set), and fetch_addr SHALL advance by 4.
REQ-021 A redirect in any state SHALL clear the FIFO and set IF_pc=redirect_pc, fetch_addr=redirect_pc&~3, skip_lo=redirect_pc[1].
REQ-022 A redirect in WAIT without mem_rvalid SHALL go to DROP; a redirect in WAIT with mem_rvalid in the same cycle SHALL discard that data and go to IDLE.
REQ-023 DROP SHALL hold mem_req=0 and discard the next mem_rvalid, then go to IDLE; a further redirect in DROP SHALL only update the PC and flags.
REQ-024 skip_lo SHALL clear after the first accepted response.
REQ-025 While redirect=1, IF_valid SHALL be 0.
REQ-026 Latency: mem_rvalid in cycle N -> IF_valid in cycle N+1; redirect in cycle 0 from IDLE -> mem_req in cycle 1.
REQ-027 The FIFO SHALL never overflow: a fetch is issued only when at most 1 halfword remains after the same-cycle consume.
REQ-028 A 32-bit instruction spanning two words (low half in slot0, count=1) SHALL stall IF_valid until the next word arrives.
REQ-029 PC and address arithmetic SHALL be 32-bit and wrap modulo 2^32.

Reset
REQ-030 On rst_n=0 asynchronously: state=IDLE, count=0, IF_pc=0, fetch_addr=0, skip_lo=0, mem_req=0, IF_valid=0, IF_Instr_32=0, IF_is_c=0.
REQ-031 Reset during WAIT SHALL abandon the outstanding request; a response arriving after reset SHALL be ignored until the first mem_req.

Configuration
REQ-032 Macro C_EXT_EN defined: behaviour per REQ-015..029.
REQ-033 Macro C_EXT_EN undefined: every word SHALL be one 32-bit instruction, IF_is_c=0, redirect_pc[1] ignored, PC step 4, and the FIFO SHALL reduce to 2 halfwords.

Verification
REQ-034 Reset, words 0x00010001 (two c.nop) at address 0 -> IF_valid with pc 0 then 2, IF_is_c=1, IF_Instr_16=0x0001; next mem_addr=4.
REQ-035 Words 0x00130001 then 0x00010000 -> c.nop at pc 0, then 32-bit 0x00000013 at pc 2, stalled until the second word arrives.
REQ-036 Redirect to 0x102 -> mem_addr=0x100; the lower halfword is dropped; the first IF_pc is 0x102.
REQ-037 Redirect in WAIT, stale mem_rvalid with 0xFFFFFFFF 3 cycles later -> data discarded, then mem_addr=new target.
REQ-038 IF_ready=0 for 10 cycles with count=2 -> no mem_req issued, IF_Instr stable, no overflow.
REQ-039 rst_n low in WAIT -> all outputs return to reset values immediately; after release, fetch restarts at 0.
